// File: rtl/gf180mcu_osu_sc_gp12t3v3__rrmux2_1.sv
// Two-source round-robin packet mux with a registered output stage.
// A multi-beat packet holds the grant until its last beat has transferred.
module gf180mcu_osu_sc_gp12t3v3__rrmux2_1 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A_data,
    input  logic             A_last,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B_data,
    input  logic             B_last,
    output logic             B_ready,
    output logic             Y_valid,
    output logic [WIDTH-1:0] Y_data,
    output logic             Y_last,
    output logic             Sel,
    input  logic             Y_ready
);

    // state  | meaning
    // IDLE   | between packets, round-robin arbitration using prio
    // LOCK_A | A is mid-packet, only A may transfer
    // LOCK_B | B is mid-packet, only B may transfer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state, state_next;
    logic   prio, prio_next;
    logic   grant_a, grant_b;
    logic   load, xfer_a, xfer_b;

    assign load    = ~Y_valid | Y_ready;
    // RN gating keeps the readies low while reset holds Y_valid at 0.
    assign A_ready = RN & load & grant_a;
    assign B_ready = RN & load & grant_b;
    assign xfer_a  = A_valid & A_ready;
    assign xfer_b  = B_valid & B_ready;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            IDLE: begin
                grant_a = A_valid & (~B_valid | ~prio);
                grant_b = B_valid & (~A_valid | prio);
            end
            LOCK_A:  grant_a = A_valid;
            LOCK_B:  grant_b = B_valid;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        prio_next  = prio;
        if (state != IDLE && state != LOCK_A && state != LOCK_B) begin
            state_next = IDLE;
        end
        if (xfer_a) begin
            if (A_last) begin
                state_next = IDLE;
                prio_next  = 1'b1;
            end else begin
                state_next = LOCK_A;
            end
        end else if (xfer_b) begin
            if (B_last) begin
                state_next = IDLE;
                prio_next  = 1'b0;
            end else begin
                state_next = LOCK_B;
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            Y_valid <= 1'b0;
            Y_data  <= '0;
            Y_last  <= 1'b0;
            Sel     <= 1'b0;
        end else if (xfer_a) begin
            Y_valid <= 1'b1;
            Y_data  <= A_data;
            Y_last  <= A_last;
            Sel     <= 1'b0;
        end else if (xfer_b) begin
            Y_valid <= 1'b1;
            Y_data  <= B_data;
            Y_last  <= B_last;
            Sel     <= 1'b1;
        end else if (Y_ready) begin
            Y_valid <= 1'b0;
        end
    end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__rrmux2_1.md
GF180MCU_OSU_SC_GP12T3V3__RRMUX2_1 -- requirements
Module: gf180mcu_osu_sc_gp12t3v3__rrmux2_1

Interface
REQ-001 SHALL have parameter: WIDTH, 8, payload width in bits (legal 1..32).
REQ-002 SHALL have port: CLK  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL have port: RN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: A_valid  input  1  source A beat valid.
REQ-005 SHALL have port: A_data  input  WIDTH  source A payload.
REQ-006 SHALL have port: A_last  input  1  source A final beat of packet.
REQ-007 SHALL have port: A_ready  output  1  source A beat accepted this cycle.
REQ-008 SHALL have ports B_valid, B_data, B_last, B_ready, identical to REQ-004..007 for source B.
REQ-009 SHALL have port: Y_valid  output  1  output register holds a beat.
REQ-010 SHALL have port: Y_data  output  WIDTH  registered payload.
REQ-011 SHALL have port: Y_last  output  1  registered last flag.
REQ-012 SHALL have port: Sel  output  1  registered source of held beat (0=A, 1=B), mux2 select polarity.
REQ-013 SHALL have port: Y_ready  input  1  consumer accepts Y beat this cycle.

Function
REQ-014 SHALL define load = ~Y_valid | Y_ready; a source transfer occurs when X_valid & X_ready at a CLK rising edge.
REQ-015 SHALL keep internal state FSM in {IDLE, LOCK_A, LOCK_B} and priority bit prio (0=A preferred, 1=B preferred).
REQ-016 IDLE: grantA = A_valid & (~B_valid | ~prio); grantB = B_valid & (~A_valid | prio); exactly one or zero grant.
REQ-017 LOCK_A: grantA = A_valid, grantB = 0; LOCK_B: grantB = B_valid, grantA = 0; B_valid/A_valid respectively SHALL be ignored.
REQ-018 SHALL drive X_ready = load & grantX combinationally; X_ready SHALL never assert when X_valid=0 is irrelevant (ready may assert only with grant).
REQ-019 On transfer from X: Y_data<=X_data, Y_last<=X_last, Sel<=(X==B), Y_valid<=1, one-cycle latency.
REQ-020 On transfer with X_last=1: FSM<=IDLE, prio<=~(X==B) (other source preferred next).
REQ-021 On transfer with X_last=0 from IDLE: FSM<=LOCK_X, prio unchanged; from LOCK_X: stay.
REQ-022 When Y_ready=1 and no transfer: Y_valid<=0; Y_data, Y_last, Sel SHALL hold.
REQ-023 When Y_valid=1 and Y_ready=0: Y_data, Y_last, Sel, Y_valid SHALL hold; both readies 0.
REQ-024 Simultaneous Y_ready=1 and new transfer SHALL give back-to-back beats (100% throughput, no bubble).
REQ-025 Single-beat packets (last=1) with both sources valid continuously SHALL alternate A,B,A,B...
REQ-026 Packet lock SHALL persist across stalls and source bubbles (X_valid=0 in LOCK_X) until X's last beat transfers.
REQ-027 Y_valid SHALL not depend combinationally on any input; Y_* and Sel SHALL be flop outputs.

Reset
REQ-028 RN=0 SHALL immediately force Y_valid=0, Y_data=0, Y_last=0, Sel=0, FSM=IDLE, prio=0, independent of CLK.
REQ-029 While RN=0, A_ready and B_ready SHALL be 0; first transfer possible on first CLK edge after RN rises.
REQ-030 Reset asserted mid-packet SHALL abandon lock; partially sent packet is not resumed.

Verification
REQ-031 Reset then A_valid=B_valid=1, last=1, A_data=0x11, B_data=0x22, Y_ready=1 -> Y_data 0x11,0x22,0x11,0x22 on successive cycles, Sel 0,1,0,1.
REQ-032 A sends 3-beat packet 0xA0,0xA1,0xA2(last) while B_valid=1 -> B_ready=0 for all 3 beats, B beat follows immediately, Sel=1.
REQ-033 Y_ready=0 for 4 cycles with Y_valid=1, Y_data=0x5A -> Y_data/Sel held, A_ready=B_ready=0; Y_ready=1 -> next beat next cycle.
REQ-034 In LOCK_B, B_valid drops 2 cycles while A_valid=1 -> A_ready stays 0; B resumes, last beat sent, then A granted.
REQ-035 RN pulsed low mid-packet of A (Y_valid=1, Y_data=0xA1) -> outputs 0 asynchronously, after release B_valid-only request granted first.
REQ-036 WIDTH=1 and WIDTH=32 builds -> REQ-031 sequence passes with data truncated/extended to width.
